// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, debounces LOCKED, then releases
// downstream domain resets one at a time; any lock loss restarts the sequence.
module pll_reset_sequencer #(
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 125000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned STAGGER_CYCLES      = 64,
  parameter int unsigned NUM_DOMAINS         = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_lock,
  input  logic                   force_reset,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic [7:0]             retry_count,
  output logic [15:0]            lock_loss_count
);

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned STG_W  = $clog2(STAGGER_CYCLES + 1);
  localparam int unsigned IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t                 r_state;
  logic                   r_lock_meta;
  logic                   r_lock_s;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic [STB_W-1:0]       r_stb_cnt;
  logic [STG_W-1:0]       r_stg_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_domain_rst_n;
  logic                   r_ready;
  logic [7:0]             r_retry_count;
  logic [15:0]            r_lock_loss_count;

  logic w_lock_lost;
  logic w_restart;

  assign w_lock_lost = ~r_lock_s & ((r_state == RELEASE) || (r_state == RUN));
  assign w_restart   = force_reset | w_lock_lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= HOLD;
      r_lock_meta       <= 1'b0;
      r_lock_s          <= 1'b0;
      r_hold_cnt        <= '0;
      r_tmo_cnt         <= '0;
      r_stb_cnt         <= '0;
      r_stg_cnt         <= '0;
      r_idx             <= '0;
      r_pll_rst         <= 1'b1;
      r_domain_rst_n    <= '0;
      r_ready           <= 1'b0;
      r_retry_count     <= '0;
      r_lock_loss_count <= '0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
      // force_reset outranks lock loss, so only a genuine loss is counted
      if (w_restart) begin
        r_state        <= HOLD;
        r_hold_cnt     <= '0;
        r_pll_rst      <= 1'b1;
        r_domain_rst_n <= '0;
        r_ready        <= 1'b0;
        if (!force_reset && (r_lock_loss_count != '1))
          r_lock_loss_count <= r_lock_loss_count + 16'd1;
      end else begin
        case (r_state)
          HOLD: begin
            r_pll_rst      <= 1'b1;
            r_domain_rst_n <= '0;
            r_ready        <= 1'b0;
            if (r_hold_cnt == HOLD_LAST) begin
              r_state    <= WAIT_LOCK;
              r_hold_cnt <= '0;
              r_tmo_cnt  <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
          WAIT_LOCK: begin
            r_pll_rst <= 1'b0;
            if (r_lock_s) begin
              r_state   <= STABLE;
              r_stb_cnt <= '0;
            end else if (r_tmo_cnt == TMO_LAST) begin
              r_state    <= HOLD;
              r_hold_cnt <= '0;
              if (r_retry_count != '1)
                r_retry_count <= r_retry_count + 8'd1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
          end
          STABLE: begin
            r_pll_rst <= 1'b0;
            if (!r_lock_s) begin
              r_state   <= WAIT_LOCK;
              r_tmo_cnt <= '0;
            end else if (r_stb_cnt == STB_LAST) begin
              r_state   <= RELEASE;
              r_stg_cnt <= '0;
              r_idx     <= '0;
            end else begin
              r_stb_cnt <= r_stb_cnt + STB_W'(1);
            end
          end
          RELEASE: begin
            if (r_stg_cnt == STG_LAST) begin
              r_domain_rst_n[r_idx] <= 1'b1;
              r_stg_cnt             <= '0;
              if (r_idx == IDX_LAST)
                r_state <= RUN;
              else
                r_idx <= r_idx + IDX_W'(1);
            end else begin
              r_stg_cnt <= r_stg_cnt + STG_W'(1);
            end
          end
          RUN: begin
            r_ready <= 1'b1;
          end
          default: begin
            r_state <= HOLD;
          end
        endcase
      end
    end
  end

  assign pll_rst         = r_pll_rst;
  assign domain_rst_n    = r_domain_rst_n;
  assign ready           = r_ready;
  assign retry_count     = r_retry_count;
  assign lock_loss_count = r_lock_loss_count;

endmodule
